instr_fetch: RTL and testbench

- Front-end stage directly upstream of instr_dec: drives MAB with the fetch address, collects the opcode word plus any source/destination extension words from MDB, and presents one complete instruction per valid/ready handshake.
- Owns the fetch PC, performs the reset-vector load, and accepts PC redirects (jumps, branches, CALL/RETI) from the execution side.
- Lets instr_dec stop comparing MAB against PC to tell instruction words from operand words.

---
 rtl/instr_fetch_pkg.sv | 39 +++
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch_len_calc.sv | 31 +++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: instruction formats, fetch states and
// constant-generator register numbers.
package instr_fetch_pkg;

  // Instruction format codes, shared with the decoder.
  typedef enum logic [1:0] {
    FmtI   = 2'd0,
    FmtII  = 2'd1,
    FmtJ   = 2'd2,
    FmtIll = 2'd3
  } fmt_e;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    FsVec  = 3'd0,
    FsOp   = 3'd1,
    FsSrc  = 3'd2,
    FsDst  = 3'd3,
    FsHold = 3'd4
  } fetch_state_e;

  // Constant-generator registers.
  localparam logic [3:0] CG1 = 4'd2;
  localparam logic [3:0] CG2 = 4'd3;

  // Classify an opcode word by format.
  function automatic fmt_e op_fmt(logic [15:0] op);
    if (op[15:12] >= 4'd4) begin
      return FmtI;
    end else if (op[15:10] == 6'b000100) begin
      return FmtII;
    end else if (op[15:13] == 3'b001) begin
      return FmtJ;
    end else begin
      return FmtIll;
    end
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory-bus and decoder-handshake signals of the fetch stage.
interface instr_fetch_if;
  logic [15:0] MAB_fetch;
  logic        mem_rd;
  logic        mem_grant;
  logic [15:0] MDB_in;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        dec_ready;
  logic        instr_valid;
  logic [15:0] instr_word;
  logic [15:0] src_ext;
  logic [15:0] dst_ext;
  logic [1:0]  instr_len;
  logic [15:0] instr_addr;
  logic [15:0] pc_next;
  logic        illegal;

  // Fetch stage side.
  modport master (
    output MAB_fetch, mem_rd, instr_valid, instr_word, src_ext, dst_ext,
           instr_len, instr_addr, pc_next, illegal,
    input  mem_grant, MDB_in, pc_load, pc_load_val, dec_ready
  );

  // Memory / execution / decoder side.
  modport slave (
    input  MAB_fetch, mem_rd, instr_valid, instr_word, src_ext, dst_ext,
           instr_len, instr_addr, pc_next, illegal,
    output mem_grant, MDB_in, pc_load, pc_load_val, dec_ready
  );
endinterface

// File: rtl/instr_fetch_len_calc.sv
// Combinational opcode inspection: which extension words follow the opcode,
// and whether the opcode is outside Format I, Format II and Jump.
module instr_fetch_len_calc
  import instr_fetch_pkg::*;
(
  input  logic [15:0] op_i,
  output logic        need_src_o,
  output logic        need_dst_o,
  output logic        illegal_o
);

  fmt_e       fmt;
  logic [3:0] src_reg;
  logic [1:0] as_mode;

  // Source extension needed for indexed/symbolic/absolute and immediate modes;
  // constant generators never fetch an extension word.
  always_comb begin
    fmt        = op_fmt(op_i);
    src_reg    = (fmt == FmtI) ? op_i[11:8] : op_i[3:0];
    as_mode    = op_i[5:4];
    need_src_o = 1'b0;
    if (fmt == FmtI || fmt == FmtII) begin
      need_src_o = (as_mode == 2'b01 && src_reg != CG2) ||
                   (as_mode == 2'b11 && src_reg == 4'd0);
    end
    need_dst_o = (fmt == FmtI) && op_i[7];
    illegal_o  = (fmt == FmtIll);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, loads the reset vector, gathers the
// opcode plus extension words and hands one bundle per valid/ready handshake.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
  parameter bit          SKIP_VECTOR  = 1'b0,
  parameter logic [15:0] RESET_PC     = 16'hC000
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  localparam fetch_state_e StReset = SKIP_VECTOR ? FsOp : FsVec;
  localparam logic [15:0]  PcReset = SKIP_VECTOR ? {RESET_PC[15:1], 1'b0} : 16'h0000;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  word_q, word_d;
  logic [15:0]  src_q, src_d;
  logic [15:0]  dst_q, dst_d;
  logic [1:0]   len_q, len_d;
  logic [15:0]  addr_q, addr_d;
  logic         ill_q, ill_d;
  logic         dst_pend_q, dst_pend_d;

  logic         need_src, need_dst, op_illegal;
  logic         rd_req, take;
  logic [15:0]  pc_plus2;

  instr_fetch_len_calc u_len_calc (
    .op_i       (bus.MDB_in),
    .need_src_o (need_src),
    .need_dst_o (need_dst),
    .illegal_o  (op_illegal)
  );

  assign rd_req   = (state_q != FsHold);
  assign take     = rd_req && bus.mem_grant;
  assign pc_plus2 = pc_q + 16'd2;

  // Next-state, PC and bundle capture; a redirect outranks everything but VEC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    word_d     = word_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    addr_d     = addr_q;
    ill_d      = ill_q;
    dst_pend_d = dst_pend_q;
    if (bus.pc_load && state_q != FsVec) begin
      pc_d    = {bus.pc_load_val[15:1], 1'b0};
      state_d = FsOp;
    end else begin
      unique case (state_q)
        FsVec: begin
          if (take) begin
            pc_d    = {bus.MDB_in[15:1], 1'b0};
            state_d = FsOp;
          end
        end
        FsOp: begin
          if (take) begin
            word_d     = bus.MDB_in;
            addr_d     = pc_q;
            pc_d       = pc_plus2;
            src_d      = 16'h0000;
            dst_d      = 16'h0000;
            ill_d      = op_illegal;
            dst_pend_d = need_dst;
            len_d      = 2'd1 + {1'b0, need_src} + {1'b0, need_dst};
            state_d    = need_src ? FsSrc : (need_dst ? FsDst : FsHold);
          end
        end
        FsSrc: begin
          if (take) begin
            src_d   = bus.MDB_in;
            pc_d    = pc_plus2;
            state_d = dst_pend_q ? FsDst : FsHold;
          end
        end
        FsDst: begin
          if (take) begin
            dst_d   = bus.MDB_in;
            pc_d    = pc_plus2;
            state_d = FsHold;
          end
        end
        FsHold: begin
          // Handshake cycle doubles as the fetch-free bubble.
          if (bus.dec_ready) state_d = FsOp;
        end
        default: state_d = StReset;
      endcase
    end
  end

  // State, PC and bundle registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReset;
      pc_q       <= PcReset;
      word_q     <= 16'h0000;
      src_q      <= 16'h0000;
      dst_q      <= 16'h0000;
      len_q      <= 2'd0;
      addr_q     <= 16'h0000;
      ill_q      <= 1'b0;
      dst_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      word_q     <= word_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      ill_q      <= ill_d;
      dst_pend_q <= dst_pend_d;
    end
  end

  assign bus.MAB_fetch   = (state_q == FsVec) ? RESET_VECTOR : pc_q;
  // Held low while reset is asserted so no read escapes during reset.
  assign bus.mem_rd      = rd_req && !rst;
  assign bus.instr_valid = (state_q == FsHold);
  assign bus.pc_next     = (state_q == FsHold) ? pc_q : 16'h0000;
  assign bus.instr_word  = word_q;
  assign bus.src_ext     = src_q;
  assign bus.dst_ext     = dst_q;
  assign bus.instr_len   = len_q;
  assign bus.instr_addr  = addr_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a small ROM model.
module tb_instr_fetch;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [15:0] rom [32768];

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_VECTOR (16'hFFFE),
    .SKIP_VECTOR  (1'b0),
    .RESET_PC     (16'hC000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.MDB_in = rom[bus.MAB_fetch[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundles: word, src, dst, len, addr, pc_next.
  localparam logic [15:0] FmtWord [4] = '{16'h4495, 16'h4035, 16'h4315, 16'h4215};
  localparam logic [15:0] FmtSrc  [4] = '{16'h0002, 16'h1234, 16'h0000, 16'h0200};
  localparam logic [15:0] FmtDst  [4] = '{16'h0004, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [1:0]  FmtLen  [4] = '{2'd3, 2'd2, 2'd1, 2'd2};
  localparam logic [15:0] FmtAddr [4] = '{16'hC002, 16'hC008, 16'hC00C, 16'hC00E};
  localparam logic [15:0] FmtNext [4] = '{16'hC008, 16'hC00C, 16'hC00E, 16'hC012};

  task automatic put(input logic [15:0] a, input logic [15:0] v);
    rom[a[15:1]] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.instr_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic handshake();
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.MAB_fetch !== 16'hFFFE) begin bad++; $display("FAIL rst.mab got=%h want=FFFE", bus.MAB_fetch); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL rst.mem_rd got=%b want=0", bus.mem_rd); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst.valid got=%b want=0", bus.instr_valid); end
    total++; if (bus.instr_len !== 2'd0) begin bad++; $display("FAIL rst.len got=%0d want=0", bus.instr_len); end
    rst = 1'b0;
    #1;
    total++; if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL vec.mem_rd got=%b want=1", bus.mem_rd); end
    step();
    total++; if (bus.MAB_fetch !== 16'hC000) begin bad++; $display("FAIL vec.pc got=%h want=C000", bus.MAB_fetch); end
  endtask

  task automatic test_single();
    step();
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL single.valid got=%b want=1", bus.instr_valid); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL single.mem_rd got=%b want=0", bus.mem_rd); end
    total++; if (bus.instr_word !== 16'h4405) begin bad++; $display("FAIL single.word got=%h want=4405", bus.instr_word); end
    total++; if (bus.instr_len !== 2'd1) begin bad++; $display("FAIL single.len got=%0d want=1", bus.instr_len); end
    total++; if (bus.instr_addr !== 16'hC000) begin bad++; $display("FAIL single.addr got=%h want=C000", bus.instr_addr); end
    total++; if (bus.pc_next !== 16'hC002) begin bad++; $display("FAIL single.pc_next got=%h want=C002", bus.pc_next); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL single.illegal got=%b want=0", bus.illegal); end
    handshake();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL single.drop got=%b want=0", bus.instr_valid); end
    total++; if (bus.MAB_fetch !== 16'hC002) begin bad++; $display("FAIL single.mab got=%h want=C002", bus.MAB_fetch); end
  endtask

  task automatic test_formats();
    bit got;
    for (int i = 0; i < 4; i++) begin
      wait_valid(got);
      total++; if (!got) begin bad++; $display("FAIL fmt%0d.timeout got=0 want=1", i); end
      total++; if (bus.instr_word !== FmtWord[i]) begin bad++; $display("FAIL fmt%0d.word got=%h want=%h", i, bus.instr_word, FmtWord[i]); end
      total++; if (bus.src_ext !== FmtSrc[i]) begin bad++; $display("FAIL fmt%0d.src got=%h want=%h", i, bus.src_ext, FmtSrc[i]); end
      total++; if (bus.dst_ext !== FmtDst[i]) begin bad++; $display("FAIL fmt%0d.dst got=%h want=%h", i, bus.dst_ext, FmtDst[i]); end
      total++; if (bus.instr_len !== FmtLen[i]) begin bad++; $display("FAIL fmt%0d.len got=%0d want=%0d", i, bus.instr_len, FmtLen[i]); end
      total++; if (bus.instr_addr !== FmtAddr[i]) begin bad++; $display("FAIL fmt%0d.addr got=%h want=%h", i, bus.instr_addr, FmtAddr[i]); end
      total++; if (bus.pc_next !== FmtNext[i]) begin bad++; $display("FAIL fmt%0d.pc_next got=%h want=%h", i, bus.pc_next, FmtNext[i]); end
      handshake();
    end
  endtask

  task automatic test_stall();
    bit got;
    step();
    bus.mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.MAB_fetch !== 16'hC014) begin bad++; $display("FAIL stall%0d.mab got=%h want=C014", i, bus.MAB_fetch); end
      total++; if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL stall%0d.mem_rd got=%b want=1", i, bus.mem_rd); end
      total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL stall%0d.valid got=%b want=0", i, bus.instr_valid); end
    end
    bus.mem_grant = 1'b1;
    wait_valid(got);
    total++; if (!got) begin bad++; $display("FAIL stall.timeout got=0 want=1"); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL hold%0d.valid got=%b want=1", i, bus.instr_valid); end
      total++; if (bus.src_ext !== 16'h0006) begin bad++; $display("FAIL hold%0d.src got=%h want=0006", i, bus.src_ext); end
      total++; if (bus.dst_ext !== 16'h0008) begin bad++; $display("FAIL hold%0d.dst got=%h want=0008", i, bus.dst_ext); end
      total++; if (bus.pc_next !== 16'hC018) begin bad++; $display("FAIL hold%0d.pc_next got=%h want=C018", i, bus.pc_next); end
      total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL hold%0d.mem_rd got=%b want=0", i, bus.mem_rd); end
    end
    handshake();
  endtask

  task automatic test_redirect();
    step();
    total++; if (bus.MAB_fetch !== 16'hC01A) begin bad++; $display("FAIL redir.src_mab got=%h want=C01A", bus.MAB_fetch); end
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 16'hD001;
    step();
    bus.pc_load = 1'b0;
    total++; if (bus.MAB_fetch !== 16'hD000) begin bad++; $display("FAIL redir.mab got=%h want=D000", bus.MAB_fetch); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL redir.valid got=%b want=0", bus.instr_valid); end
    step();
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL ill.valid got=%b want=1", bus.instr_valid); end
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL ill.flag got=%b want=1", bus.illegal); end
    total++; if (bus.instr_len !== 2'd1) begin bad++; $display("FAIL ill.len got=%0d want=1", bus.instr_len); end
    total++; if (bus.instr_addr !== 16'hD000) begin bad++; $display("FAIL ill.addr got=%h want=D000", bus.instr_addr); end
    total++; if (bus.src_ext !== 16'h0000) begin bad++; $display("FAIL ill.src got=%h want=0000", bus.src_ext); end
    total++; if (bus.pc_next !== 16'hD002) begin bad++; $display("FAIL ill.pc_next got=%h want=D002", bus.pc_next); end
    handshake();
  endtask

  task automatic test_jump_fmt2();
    bit got;
    wait_valid(got);
    total++; if (!got) begin bad++; $display("FAIL jmp.timeout got=0 want=1"); end
    total++; if (bus.instr_len !== 2'd1) begin bad++; $display("FAIL jmp.len got=%0d want=1", bus.instr_len); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL jmp.illegal got=%b want=0", bus.illegal); end
    total++; if (bus.pc_next !== 16'hD004) begin bad++; $display("FAIL jmp.pc_next got=%h want=D004", bus.pc_next); end
    handshake();
    wait_valid(got);
    total++; if (!got) begin bad++; $display("FAIL f2.timeout got=0 want=1"); end
    total++; if (bus.instr_len !== 2'd2) begin bad++; $display("FAIL f2.len got=%0d want=2", bus.instr_len); end
    total++; if (bus.src_ext !== 16'h0004) begin bad++; $display("FAIL f2.src got=%h want=0004", bus.src_ext); end
    total++; if (bus.dst_ext !== 16'h0000) begin bad++; $display("FAIL f2.dst got=%h want=0000", bus.dst_ext); end
    total++; if (bus.pc_next !== 16'hD008) begin bad++; $display("FAIL f2.pc_next got=%h want=D008", bus.pc_next); end
    handshake();
  endtask

  task automatic test_wrap();
    bit got;
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 16'hFFFC;
    step();
    bus.pc_load = 1'b0;
    total++; if (bus.MAB_fetch !== 16'hFFFC) begin bad++; $display("FAIL wrap.mab got=%h want=FFFC", bus.MAB_fetch); end
    wait_valid(got);
    total++; if (!got) begin bad++; $display("FAIL wrap.timeout got=0 want=1"); end
    total++; if (bus.src_ext !== 16'hC000) begin bad++; $display("FAIL wrap.src got=%h want=C000", bus.src_ext); end
    total++; if (bus.dst_ext !== 16'h1357) begin bad++; $display("FAIL wrap.dst got=%h want=1357", bus.dst_ext); end
    total++; if (bus.pc_next !== 16'h0002) begin bad++; $display("FAIL wrap.pc_next got=%h want=0002", bus.pc_next); end
    // Redirect coincident with the handshake.
    bus.dec_ready   = 1'b1;
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 16'hC000;
    step();
    bus.dec_ready = 1'b0;
    bus.pc_load   = 1'b0;
    total++; if (bus.MAB_fetch !== 16'hC000) begin bad++; $display("FAIL hsredir.mab got=%h want=C000", bus.MAB_fetch); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL hsredir.valid got=%b want=0", bus.instr_valid); end
    wait_valid(got);
    total++; if (!got) begin bad++; $display("FAIL hsredir.timeout got=0 want=1"); end
    total++; if (bus.instr_word !== 16'h4405) begin bad++; $display("FAIL hsredir.word got=%h want=4405", bus.instr_word); end
    handshake();
  endtask

  task automatic test_async_reset();
    bit got;
    step();
    #3;
    rst = 1'b1;
    #1;
    total++; if (bus.MAB_fetch !== 16'hFFFE) begin bad++; $display("FAIL arst.mab got=%h want=FFFE", bus.MAB_fetch); end
    total++; if (bus.instr_len !== 2'd0) begin bad++; $display("FAIL arst.len got=%0d want=0", bus.instr_len); end
    total++; if (bus.instr_word !== 16'h0000) begin bad++; $display("FAIL arst.word got=%h want=0000", bus.instr_word); end
    step();
    rst             = 1'b0;
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 16'hD000;
    step();
    bus.pc_load = 1'b0;
    total++; if (bus.MAB_fetch !== 16'hC000) begin bad++; $display("FAIL vecload.mab got=%h want=C000", bus.MAB_fetch); end
    wait_valid(got);
    total++; if (!got) begin bad++; $display("FAIL arst.timeout got=0 want=1"); end
    total++; if (bus.instr_addr !== 16'hC000) begin bad++; $display("FAIL arst.addr got=%h want=C000", bus.instr_addr); end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    bus.mem_grant   = 1'b1;
    bus.dec_ready   = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = 16'h0000;
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
    put(16'hFFFE, 16'hC000);
    put(16'hC000, 16'h4405);
    put(16'hC002, 16'h4495); put(16'hC004, 16'h0002); put(16'hC006, 16'h0004);
    put(16'hC008, 16'h4035); put(16'hC00A, 16'h1234);
    put(16'hC00C, 16'h4315);
    put(16'hC00E, 16'h4215); put(16'hC010, 16'h0200);
    put(16'hC012, 16'h4495); put(16'hC014, 16'h0006); put(16'hC016, 16'h0008);
    put(16'hC018, 16'h4495); put(16'hC01A, 16'h1111); put(16'hC01C, 16'h2222);
    put(16'hD002, 16'h3C00);
    put(16'hD004, 16'h1295); put(16'hD006, 16'h0004);
    put(16'hD008, 16'h4405);
    put(16'hFFFC, 16'h4495);
    put(16'h0000, 16'h1357);

    test_reset();
    test_single();
    test_formats();
    test_stall();
    test_redirect();
    test_jump_fmt2();
    test_wrap();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
